// File: rtl/vic_bus_initiator.sv
// CPU-side initiator that runs single VIC-II register reads/writes as phi-aligned 6510 bus cycles.
// Define VIC_BUS_INIT_TIMEOUT_EN to abort requests stalled for TIMEOUT_CYCLES phi cycles with rsp_err.
module vic_bus_initiator #(
  parameter int SAMPLE_TICK    = 14,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk_dot4x,
  input  logic       rst_n,
  input  logic       clk_phi,
  input  logic       aec,
  input  logic       ba,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [5:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       ce,
  output logic       rw,
  output logic [5:0] adl_out,
  output logic       adl_oe,
  input  logic [7:0] dbl_in,
  output logic [7:0] dbl_out,
  output logic       dbl_oe
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_PHI1,
    S_PHI2,
    S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic       phi_q;
  logic       rise, fall, grant;
  logic       ce_q, ce_d;
  logic       rw_q, rw_d;
  logic       adl_oe_q, adl_oe_d;
  logic [5:0] adl_out_q, adl_out_d;
  logic       dbl_oe_q, dbl_oe_d;
  logic [7:0] dbl_out_q, dbl_out_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic [4:0] tick_q, tick_d, tick_inc;
  logic       sampled_q, sampled_d;
  logic       lat_rw_q, lat_rw_d;
  logic [5:0] lat_addr_q, lat_addr_d;
  logic [7:0] lat_wdata_q, lat_wdata_d;
`ifdef VIC_BUS_INIT_TIMEOUT_EN
  logic [7:0] stall_cnt_q, stall_cnt_d;
  logic       rsp_err_q, rsp_err_d;
`endif

  if (SAMPLE_TICK < 1 || SAMPLE_TICK > 15 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
    $error("vic_bus_initiator: SAMPLE_TICK or TIMEOUT_CYCLES out of range");
  end

  assign rise     = clk_phi & ~phi_q;
  assign fall     = ~clk_phi & phi_q;
  // Reads must also wait for ba; writes only need the bus (aec).
  assign grant    = aec & (~lat_rw_q | ba);
  assign tick_inc = (tick_q == 5'd31) ? 5'd31 : tick_q + 5'd1;

  always_comb begin
    state_d     = state_q;
    ce_d        = ce_q;
    rw_d        = rw_q;
    adl_oe_d    = adl_oe_q;
    adl_out_d   = adl_out_q;
    dbl_oe_d    = dbl_oe_q;
    dbl_out_d   = dbl_out_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    tick_d      = tick_q;
    sampled_d   = sampled_q;
    lat_rw_d    = lat_rw_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
`ifdef VIC_BUS_INIT_TIMEOUT_EN
    stall_cnt_d = stall_cnt_q;
    rsp_err_d   = rsp_err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          lat_rw_d    = req_rw;
          lat_addr_d  = req_addr;
          lat_wdata_d = req_wdata;
`ifdef VIC_BUS_INIT_TIMEOUT_EN
          stall_cnt_d = 8'd0;
`endif
          state_d     = S_ARM;
        end
      end
      // Only a fresh fall starts phi1, so address setup is always a full half-period.
      S_ARM: begin
        if (fall) begin
          adl_oe_d  = 1'b1;
          adl_out_d = lat_addr_q;
          rw_d      = lat_rw_q;
          state_d   = S_PHI1;
        end
      end
      S_PHI1: begin
        if (rise) begin
          if (grant) begin
            ce_d      = 1'b0;
            tick_d    = 5'd0;
            sampled_d = 1'b0;
            if (!lat_rw_q) begin
              dbl_oe_d  = 1'b1;
              dbl_out_d = lat_wdata_q;
            end
            state_d = S_PHI2;
          end else begin
            adl_oe_d = 1'b0;
            rw_d     = 1'b1;
`ifdef VIC_BUS_INIT_TIMEOUT_EN
            stall_cnt_d = stall_cnt_q + 8'd1;
            if (stall_cnt_d == 8'(TIMEOUT_CYCLES)) begin
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
              state_d     = S_DONE;
            end else begin
              state_d = S_ARM;
            end
`else
            state_d = S_ARM;
`endif
          end
        end
      end
      S_PHI2: begin
        tick_d = tick_inc;
        if (lat_rw_q && !sampled_q && tick_inc == 5'(SAMPLE_TICK)) begin
          rsp_rdata_d = dbl_in;
          sampled_d   = 1'b1;
        end
        if (fall) begin
          if (lat_rw_q && !sampled_q) begin
            rsp_rdata_d = dbl_in;
            sampled_d   = 1'b1;
          end
          ce_d        = 1'b1;
          rw_d        = 1'b1;
          adl_oe_d    = 1'b0;
          dbl_oe_d    = 1'b0;
          rsp_valid_d = 1'b1;
`ifdef VIC_BUS_INIT_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      phi_q       <= 1'b0;
      ce_q        <= 1'b1;
      rw_q        <= 1'b1;
      adl_oe_q    <= 1'b0;
      adl_out_q   <= 6'd0;
      dbl_oe_q    <= 1'b0;
      dbl_out_q   <= 8'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'd0;
      tick_q      <= 5'd0;
      sampled_q   <= 1'b0;
`ifdef VIC_BUS_INIT_TIMEOUT_EN
      stall_cnt_q <= 8'd0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      phi_q       <= clk_phi;
      ce_q        <= ce_d;
      rw_q        <= rw_d;
      adl_oe_q    <= adl_oe_d;
      adl_out_q   <= adl_out_d;
      dbl_oe_q    <= dbl_oe_d;
      dbl_out_q   <= dbl_out_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      tick_q      <= tick_d;
      sampled_q   <= sampled_d;
`ifdef VIC_BUS_INIT_TIMEOUT_EN
      stall_cnt_q <= stall_cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  // Request fields are only consumed after acceptance, so they carry no reset.
  always_ff @(posedge clk_dot4x) begin
    lat_rw_q    <= lat_rw_d;
    lat_addr_q  <= lat_addr_d;
    lat_wdata_q <= lat_wdata_d;
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign ce        = ce_q;
  assign rw        = rw_q;
  assign adl_oe    = adl_oe_q;
  assign adl_out   = adl_out_q;
  assign dbl_oe    = dbl_oe_q;
  assign dbl_out   = dbl_out_q;
`ifdef VIC_BUS_INIT_TIMEOUT_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_vic_bus_initiator.sv
// Self-checking bench for vic_bus_initiator: directed bus-cycle scenarios plus randomized requests
// checked against a phi-cycle-level model of grant, timing and read sampling.
module tb_vic_bus_initiator;
  localparam int SAMPLE_TICK    = 14;
  localparam int TIMEOUT_CYCLES = 4;

  logic       clk_dot4x = 1'b0;
  logic       rst_n     = 1'b0;
  logic       clk_phi   = 1'b0;
  logic       aec       = 1'b1;
  logic       ba        = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_rw    = 1'b0;
  logic [5:0] req_addr  = 6'd0;
  logic [7:0] req_wdata = 8'd0;
  logic [7:0] dbl_in    = 8'd0;
  logic       req_ready, rsp_valid, rsp_err, ce, rw, adl_oe, dbl_oe;
  logic [7:0] rsp_rdata, dbl_out;
  logic [5:0] adl_out;

  int n_checks = 0;
  int n_errors = 0;
  logic [4:0] phi_cnt = 5'd0;

  // per-phi-cycle arbitration schedule, index = phi cycle number after acceptance
  logic aec_s [16];
  logic ba_s  [16];
  logic [7:0] model_rdata = 8'd0;

  int obs_ce_low, obs_access_phi, obs_setup, obs_bus_bad, obs_read_bad, obs_ready_bad;
  int obs_rsp_count, obs_rsp_lat, obs_rsp_phi;
  logic obs_rsp_err, obs_ready0;
  logic [7:0] obs_rdata, exp_rdata;

  vic_bus_initiator #(.SAMPLE_TICK(SAMPLE_TICK), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk_dot4x(clk_dot4x), .rst_n(rst_n), .clk_phi(clk_phi), .aec(aec), .ba(ba),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ce(ce), .rw(rw), .adl_out(adl_out), .adl_oe(adl_oe), .dbl_in(dbl_in),
    .dbl_out(dbl_out), .dbl_oe(dbl_oe)
  );

  always #5 clk_dot4x = ~clk_dot4x;

  // phi: 32 dot4x cycles per period, 16 high, changed away from the active edge
  always @(negedge clk_dot4x) begin
    phi_cnt = phi_cnt + 5'd1;
    clk_phi = phi_cnt[4];
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic aec_at(input int k);
    return aec_s[(k > 15) ? 15 : k];
  endfunction

  function automatic logic ba_at(input int k);
    return ba_s[(k > 15) ? 15 : k];
  endfunction

  // first phi cycle in which the bus is granted for this kind of access (0 = none)
  function automatic int model_grant(input logic t_rw, input int limit);
    for (int k = 1; k <= limit; k++)
      if (aec_at(k) && (!t_rw || ba_at(k))) return k;
    return 0;
  endfunction

  task automatic step();
    @(negedge clk_dot4x);
    #1;
  endtask

  task automatic set_sched(input logic a, input logic b);
    for (int k = 0; k < 16; k++) begin
      aec_s[k] = a;
      ba_s[k]  = b;
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    model_rdata = 8'd0;
  endtask

  // Drives one request and records what the bus and response did, cycle by cycle.
  task automatic run_txn(input logic t_rw, input logic [5:0] t_addr, input logic [7:0] t_wdata,
                         input int budget, input bit drop_ba, input bit fixed_pat);
    int nfall, s_rise, s_edge, s_rsp, run;
    logic phi_prev;
    obs_ce_low = 0; obs_access_phi = 0; obs_setup = 0; obs_bus_bad = 0; obs_read_bad = 0;
    obs_ready_bad = 0; obs_rsp_count = 0; obs_rsp_lat = -1; obs_rsp_phi = -1;
    obs_rsp_err = 1'b0; obs_rdata = 8'd0; exp_rdata = 8'd0;
    nfall = 0; s_rise = -100; s_edge = -100; s_rsp = -1; run = 0;
    obs_ready0 = req_ready;
    req_valid = 1'b1; req_rw = t_rw; req_addr = t_addr; req_wdata = t_wdata;
    aec = aec_at(0); ba = ba_at(0);
    phi_prev = clk_phi;
    for (int s = 1; s <= budget; s++) begin
      step();
      req_valid = 1'b0;
      req_addr  = 6'($urandom);
      req_wdata = 8'($urandom);
      if (s_rsp < 0 && req_ready === 1'b1) obs_ready_bad++;
      if (!clk_phi && phi_prev) begin
        nfall++;
        s_edge = s;
        aec = aec_at(nfall);
        ba  = ba_at(nfall);
      end
      if (clk_phi && !phi_prev) begin
        s_edge = s;
        s_rise = s;
      end
      phi_prev = clk_phi;
      if (drop_ba && ce === 1'b0) ba = 1'($urandom);
      if (fixed_pat && s - s_rise >= 15) dbl_in = 8'hFF;
      else if (fixed_pat && s - s_rise >= 10) dbl_in = 8'h37;
      else dbl_in = 8'($urandom);
      if (s == s_rise + SAMPLE_TICK) exp_rdata = dbl_in;
      if (ce === 1'b0) begin
        if (obs_ce_low == 0) begin
          obs_access_phi = nfall;
          obs_setup = run;
        end
        obs_ce_low++;
        if (rw !== t_rw || adl_oe !== 1'b1 || adl_out !== t_addr || dbl_oe !== ~t_rw ||
            (!t_rw && dbl_out !== t_wdata)) obs_bus_bad++;
      end else if (adl_oe === 1'b1 && adl_out === t_addr && rw === t_rw) run++;
      else run = 0;
      if (t_rw && (rw !== 1'b1 || dbl_oe !== 1'b0)) obs_read_bad++;
      if (rsp_valid === 1'b1) begin
        obs_rsp_count++;
        if (s_rsp < 0) begin
          s_rsp = s;
          obs_rsp_lat = s - s_edge;
          obs_rsp_phi = nfall;
          obs_rsp_err = rsp_err;
          obs_rdata = rsp_rdata;
        end
      end
      if (s_rsp > 0 && s >= s_rsp + 2) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    n_checks++; if (ce !== 1'b1) begin n_errors++; $display("FAIL reset_ce: got %0b expected 1", ce); end
    n_checks++; if (rw !== 1'b1) begin n_errors++; $display("FAIL reset_rw: got %0b expected 1", rw); end
    n_checks++; if (adl_oe !== 1'b0) begin n_errors++; $display("FAIL reset_adl_oe: got %0b expected 0", adl_oe); end
    n_checks++; if (dbl_oe !== 1'b0) begin n_errors++; $display("FAIL reset_dbl_oe: got %0b expected 0", dbl_oe); end
    n_checks++; if (adl_out !== 6'd0) begin n_errors++; $display("FAIL reset_adl_out: got %0h expected 0", adl_out); end
    n_checks++; if (dbl_out !== 8'd0) begin n_errors++; $display("FAIL reset_dbl_out: got %0h expected 0", dbl_out); end
    n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_req_ready: got %0b expected 1", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_valid: got %0b expected 0", rsp_valid); end
    n_checks++; if (rsp_rdata !== 8'd0) begin n_errors++; $display("FAIL reset_rsp_rdata: got %0h expected 0", rsp_rdata); end
    n_checks++; if (rsp_err !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_err: got %0b expected 0", rsp_err); end
    rst_n = 1'b1;
    step();
    model_rdata = 8'd0;
  endtask

  task automatic test_write_basic();
    set_sched(1'b1, 1'b1);
    run_txn(1'b0, 6'h20, 8'h0E, 200, 1'b0, 1'b0);
    n_checks++; if (obs_ready0 !== 1'b1) begin n_errors++; $display("FAIL wr_ready_idle: got %0b expected 1", obs_ready0); end
    n_checks++; if (obs_ce_low !== 16) begin n_errors++; $display("FAIL wr_ce_low_cycles: got %0d expected 16", obs_ce_low); end
    n_checks++; if (obs_access_phi !== 1) begin n_errors++; $display("FAIL wr_access_phi: got %0d expected 1", obs_access_phi); end
    n_checks++; if (obs_bus_bad !== 0) begin n_errors++; $display("FAIL wr_bus_values: got %0d bad cycles expected 0", obs_bus_bad); end
    n_checks++; if (obs_setup !== 16) begin n_errors++; $display("FAIL wr_addr_setup: got %0d expected 16", obs_setup); end
    n_checks++; if (obs_rsp_count !== 1) begin n_errors++; $display("FAIL wr_rsp_pulses: got %0d expected 1", obs_rsp_count); end
    n_checks++; if (obs_rsp_lat !== 1) begin n_errors++; $display("FAIL wr_rsp_after_fall: got %0d expected 1", obs_rsp_lat); end
    n_checks++; if (obs_rsp_err !== 1'b0) begin n_errors++; $display("FAIL wr_rsp_err: got %0b expected 0", obs_rsp_err); end
    n_checks++; if (obs_rdata !== model_rdata) begin n_errors++; $display("FAIL wr_rdata_hold: got %0h expected %0h", obs_rdata, model_rdata); end
    n_checks++; if (obs_ready_bad !== 0) begin n_errors++; $display("FAIL wr_ready_busy: got %0d expected 0", obs_ready_bad); end
  endtask

  task automatic test_read_sample();
    set_sched(1'b1, 1'b1);
    repeat (7) step();
    run_txn(1'b1, 6'h12, 8'h00, 200, 1'b0, 1'b1);
    n_checks++; if (obs_rdata !== 8'h37) begin n_errors++; $display("FAIL rd_sample_data: got %0h expected 37", obs_rdata); end
    n_checks++; if (obs_read_bad !== 0) begin n_errors++; $display("FAIL rd_rw_dbl_oe: got %0d bad cycles expected 0", obs_read_bad); end
    n_checks++; if (obs_ce_low !== 16) begin n_errors++; $display("FAIL rd_ce_low_cycles: got %0d expected 16", obs_ce_low); end
    n_checks++; if (obs_bus_bad !== 0) begin n_errors++; $display("FAIL rd_bus_values: got %0d expected 0", obs_bus_bad); end
    model_rdata = 8'h37;
  endtask

  task automatic test_read_ba_stall();
    set_sched(1'b1, 1'b1);
    for (int k = 1; k <= 3; k++) ba_s[k] = 1'b0;
    run_txn(1'b1, 6'h05, 8'h00, 400, 1'b0, 1'b0);
    n_checks++; if (obs_access_phi !== 4) begin n_errors++; $display("FAIL ba_stall_access_phi: got %0d expected 4", obs_access_phi); end
    n_checks++; if (obs_ce_low !== 16) begin n_errors++; $display("FAIL ba_stall_ce_low: got %0d expected 16", obs_ce_low); end
    n_checks++; if (obs_rsp_err !== 1'b0 || obs_rsp_count !== 1) begin n_errors++; $display("FAIL ba_stall_rsp: got err=%0b pulses=%0d expected err=0 pulses=1", obs_rsp_err, obs_rsp_count); end
    n_checks++; if (obs_rdata !== exp_rdata) begin n_errors++; $display("FAIL ba_stall_rdata: got %0h expected %0h", obs_rdata, exp_rdata); end
    model_rdata = exp_rdata;
  endtask

  task automatic test_write_ba_low();
    set_sched(1'b1, 1'b0);
    run_txn(1'b0, 6'h3F, 8'hA5, 200, 1'b0, 1'b0);
    n_checks++; if (obs_access_phi !== 1) begin n_errors++; $display("FAIL wr_ba_low_access_phi: got %0d expected 1", obs_access_phi); end
    n_checks++; if (obs_bus_bad !== 0 || obs_ce_low !== 16) begin n_errors++; $display("FAIL wr_ba_low_bus: got bad=%0d low=%0d expected bad=0 low=16", obs_bus_bad, obs_ce_low); end
  endtask

  task automatic test_random();
    logic t_rw;
    logic [5:0] t_addr;
    logic [7:0] t_wdata;
    int k;
    for (int n = 0; n < 24; n++) begin
      t_rw = 1'($urandom);
      t_addr = 6'($urandom);
      t_wdata = 8'($urandom);
      set_sched(1'b1, 1'b1);
      for (int j = 0; j <= 2; j++) begin
        aec_s[j] = ($urandom_range(0, 3) != 0);
        ba_s[j]  = 1'($urandom);
      end
      k = model_grant(t_rw, 15);
      repeat ($urandom_range(0, 40)) step();
      run_txn(t_rw, t_addr, t_wdata, 300, 1'($urandom), 1'b0);
      n_checks++; if (obs_access_phi !== k) begin n_errors++; $display("FAIL rnd%0d_access_phi: got %0d expected %0d", n, obs_access_phi, k); end
      n_checks++; if (obs_ce_low !== 16) begin n_errors++; $display("FAIL rnd%0d_ce_low: got %0d expected 16", n, obs_ce_low); end
      n_checks++; if (obs_setup !== 16) begin n_errors++; $display("FAIL rnd%0d_addr_setup: got %0d expected 16", n, obs_setup); end
      n_checks++; if (obs_bus_bad !== 0 || obs_read_bad !== 0) begin n_errors++; $display("FAIL rnd%0d_bus: got bad=%0d rdbad=%0d expected 0", n, obs_bus_bad, obs_read_bad); end
      n_checks++; if (obs_rsp_count !== 1 || obs_rsp_lat !== 1) begin n_errors++; $display("FAIL rnd%0d_rsp_timing: got pulses=%0d lat=%0d expected 1/1", n, obs_rsp_count, obs_rsp_lat); end
      n_checks++; if (obs_rsp_phi !== k + 1) begin n_errors++; $display("FAIL rnd%0d_rsp_phi: got %0d expected %0d", n, obs_rsp_phi, k + 1); end
      n_checks++; if (obs_rsp_err !== 1'b0) begin n_errors++; $display("FAIL rnd%0d_rsp_err: got %0b expected 0", n, obs_rsp_err); end
      if (t_rw) model_rdata = exp_rdata;
      n_checks++; if (obs_rdata !== model_rdata) begin n_errors++; $display("FAIL rnd%0d_rdata: got %0h expected %0h", n, obs_rdata, model_rdata); end
      n_checks++; if (obs_ready0 !== 1'b1 || obs_ready_bad !== 0) begin n_errors++; $display("FAIL rnd%0d_ready: got idle=%0b busybad=%0d expected 1/0", n, obs_ready0, obs_ready_bad); end
    end
  endtask

  task automatic test_timeout();
    set_sched(1'b0, 1'b1);
`ifdef VIC_BUS_INIT_TIMEOUT_EN
    run_txn(1'b0, 6'h11, 8'h22, TIMEOUT_CYCLES * 32 + 80, 1'b0, 1'b0);
    n_checks++; if (obs_rsp_count !== 1 || obs_rsp_err !== 1'b1) begin n_errors++; $display("FAIL to_rsp: got pulses=%0d err=%0b expected 1/1", obs_rsp_count, obs_rsp_err); end
    n_checks++; if (obs_rsp_phi !== TIMEOUT_CYCLES || obs_rsp_lat !== 1) begin n_errors++; $display("FAIL to_timing: got phi=%0d lat=%0d expected %0d/1", obs_rsp_phi, obs_rsp_lat, TIMEOUT_CYCLES); end
    n_checks++; if (obs_ce_low !== 0) begin n_errors++; $display("FAIL to_ce_never_low: got %0d expected 0", obs_ce_low); end
    n_checks++; if (obs_rdata !== model_rdata) begin n_errors++; $display("FAIL to_rdata_hold: got %0h expected %0h", obs_rdata, model_rdata); end
`else
    run_txn(1'b0, 6'h11, 8'h22, 100 * 32 + 40, 1'b0, 1'b0);
    n_checks++; if (obs_rsp_count !== 0) begin n_errors++; $display("FAIL noto_no_rsp: got %0d pulses expected 0", obs_rsp_count); end
    n_checks++; if (obs_ce_low !== 0) begin n_errors++; $display("FAIL noto_ce_never_low: got %0d expected 0", obs_ce_low); end
    reset_dut();
`endif
    // a fresh request gets a fresh stall budget
    set_sched(1'b0, 1'b1);
    for (int k = 4; k < 16; k++) aec_s[k] = 1'b1;
    run_txn(1'b0, 6'h2A, 8'h5C, 400, 1'b0, 1'b0);
    n_checks++; if (obs_access_phi !== 4 || obs_rsp_err !== 1'b0) begin n_errors++; $display("FAIL stall3_after: got phi=%0d err=%0b expected 4/0", obs_access_phi, obs_rsp_err); end
  endtask

  task automatic test_reset_mid();
    int low_seen;
    int pulses;
    set_sched(1'b1, 1'b1);
    aec = 1'b1; ba = 1'b1;
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 6'h09; req_wdata = 8'hC3;
    step();
    req_valid = 1'b0;
    low_seen = 0;
    for (int s = 0; s < 120 && low_seen == 0; s++) begin
      if (ce === 1'b0) low_seen = 1;
      else step();
    end
    n_checks++;
    if (low_seen == 0) begin
      n_errors++; $display("FAIL rstmid_reach_phi2: got no access expected ce low within 120 cycles");
    end else begin
      repeat (5) step();
      #1;
      rst_n = 1'b0;
      #1;
      n_checks++; if (ce !== 1'b1 || dbl_oe !== 1'b0) begin n_errors++; $display("FAIL rstmid_release: got ce=%0b dbl_oe=%0b expected 1/0", ce, dbl_oe); end
      n_checks++; if (adl_oe !== 1'b0 || rw !== 1'b1) begin n_errors++; $display("FAIL rstmid_addr: got adl_oe=%0b rw=%0b expected 0/1", adl_oe, rw); end
    end
    repeat (3) step();
    rst_n = 1'b1;
    step();
    model_rdata = 8'd0;
    n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL rstmid_ready: got %0b expected 1", req_ready); end
    pulses = 0;
    for (int s = 0; s < 80; s++) begin
      if (rsp_valid === 1'b1) pulses++;
      step();
    end
    n_checks++; if (pulses !== 0) begin n_errors++; $display("FAIL rstmid_no_rsp: got %0d pulses expected 0", pulses); end
  endtask

  initial begin
    rst_n = 1'b0;
    step();
    test_reset();
    test_write_basic();
    test_read_sample();
    test_read_ba_stall();
    test_write_ba_low();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vic_bus_initiator.md
# vic_bus_initiator

CPU-side bus initiator for the VIC-II register port. It takes single register read/write requests from an on-chip requester and runs them as 6510-style bus cycles on `ce`, `rw`, the low address lines and the data bus. Each cycle is aligned to `clk_phi` and honours `aec`/`ba` bus arbitration. It is the responder-facing counterpart of the `vicii` register interface, used for the bus exerciser and board self-test, and runs entirely in the `clk_dot4x` domain.

## Interface
Parameters:
- `SAMPLE_TICK`, 14: `clk_dot4x` cycles after the phi rising edge at which read data is sampled; legal range 1..15.
- `TIMEOUT_CYCLES`, 64: number of consecutive stalled phi cycles before the request is aborted with an error; legal range 1..255.

Ports:
- `clk_dot4x` in 1: the only clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `clk_phi` in 1: phi clock; generated from `clk_dot4x`, so it is synchronous to it.
- `aec` in 1: high when the CPU side owns the bus.
- `ba` in 1: low when VIC DMA is pending; stalls reads only.
- `req_valid` in 1 / `req_ready` out 1: request handshake.
- `req_rw` in 1: 1 = read, 0 = write.
- `req_addr` in 6: register address.
- `req_wdata` in 8: write data.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 8: read data.
- `rsp_err` out 1: request timed out; qualified by `rsp_valid`.
- `ce` out 1: chip enable, active-low.
- `rw` out 1: bus read/write.
- `adl_out` out 6 / `adl_oe` out 1: address lines and their enable.
- `dbl_in` in 8: data bus input.
- `dbl_out` out 8 / `dbl_oe` out 1: data bus lines and their enable.

## Operation
- Edge detect: `phi_d` is `clk_phi` registered. `rise` = `clk_phi & ~phi_d`; `fall` = `~clk_phi & phi_d`.
- **IDLE**:
  - `req_ready`=1.
  - On `req_valid & req_ready`, latch rw, addr and wdata; clear `stall_cnt`; go to ARM.
- **ARM**:
  - Wait for `fall`; it marks the start of phi1.
  - A request accepted while phi is already low still waits for the next `fall`, so phi1 setup is always full-length.
  - On `fall`: `adl_oe`=1, `adl_out`=addr, `rw`=latched rw. Go to PHI1.
- **PHI1**, on `rise`:
  - Grant: `aec`=1 and (write, or `ba`=1). Set `ce`=0; for a write set `dbl_oe`=1 and `dbl_out`=wdata. Clear `tick`. Go to PHI2.
  - Otherwise, stall: `adl_oe`=0, `rw`=1, increment `stall_cnt`.
    - If `stall_cnt` reaches `TIMEOUT_CYCLES`, go to DONE with error set.
    - Otherwise go back to ARM.
- **PHI2**:
  - `tick` increments each cycle and saturates at 31 (5-bit).
  - On a read, `rsp_rdata` ← `dbl_in` when `tick`==`SAMPLE_TICK`.
  - On `fall`:
    - If the sample has not happened yet, sample `dbl_in` now.
    - Release the bus: `ce`=1, `rw`=1, `adl_oe`=0, `dbl_oe`=0.
    - Go to DONE.
- **DONE**:
  - `rsp_valid`=1 for exactly one cycle; `rsp_err` is 1 only on timeout. Return to IDLE.
  - `rsp_rdata` holds until the next read completes; writes leave it unchanged.
- Only one request is outstanding at a time. `req_ready`=0 in every state except IDLE.

## Timing
- Reset values: `ce`=1, `rw`=1, `adl_oe`=0, `dbl_oe`=0, `adl_out`=0, `dbl_out`=0, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0; state IDLE.
- Asserting `rst_n` low mid-cycle releases all bus outputs immediately (asynchronously). No response is issued for the aborted request.
- All outputs are registered. The first bus output change happens on the clock edge in which `fall` is detected.
- Latency without stall, from acceptance to `rsp_valid`: at most 2 phi periods plus 1 `clk_dot4x` cycle.
- A phi period is 32 `clk_dot4x` cycles; phi2 is 16 of them.
- `ce` is low exactly from the `rise` edge to the `fall` edge (16 cycles).
- Address and `rw` are stable 16 cycles before `ce` falls and stay stable until `ce` rises.
- A `ba` drop during PHI2 does not abort an access already in progress.

## Configuration
- `VIC_BUS_INIT_TIMEOUT_EN` defined: timeout logic as described above, with an 8-bit `stall_cnt`.
- Not defined: `stall_cnt` and the timeout logic are removed, and the block waits indefinitely for a grant. `rsp_err` is tied to 0.

## Test plan
- Write with `aec`=1, `ba`=1, addr 0x20, data 0x0E:
  - `ce` low for 16 cycles; `rw`=0; `dbl_oe`=1 with `dbl_out`=0x0E.
  - `rsp_valid` 1 cycle after phi falls; `rsp_err`=0.
- Read of addr 0x12 with `dbl_in`=0x37 from tick 10 and 0xFF from tick 15, `SAMPLE_TICK`=14:
  - Requires `rsp_rdata`=0x37; `rw`=1 and `dbl_oe`=0 throughout.
- Read with `ba`=0 for 3 phi cycles, then `ba`=1:
  - `ce` stays 1 for 3 cycles; the access happens in the 4th; `rsp_err`=0.
- Write with `ba`=0 and `aec`=1: proceeds in the first phi cycle.
- Timeout, macro defined, `TIMEOUT_CYCLES`=4, `aec` held 0:
  - `rsp_valid` with `rsp_err`=1 after the 4th rise; `ce` never 0.
  - Macro undefined: no response after 100 phi cycles.
- `rst_n` pulsed low during PHI2 of a write:
  - `ce`=1 and `dbl_oe`=0 immediately; `req_ready`=1 after release; no `rsp_valid`.
